// File: rtl/exp_lut_harness.sv
// On-chip vector player/recorder for the combinational exp_lut: plays loaded
// vectors onto lut_in, samples lut_out after a settle window, streams pairs back.
module exp_lut_harness #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] lut_in,
  input  logic [DATA_W-1:0] lut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_in,
  output logic [DATA_W-1:0] res_out,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a stalled payload holds still.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [3:0]          wait_cnt;
  logic [DATA_W-1:0]   vec_mem [DEPTH];
  logic [DATA_W-1:0]   res_mem [DEPTH];
  logic                last_idx;
  logic                load_fire;

  assign last_idx   = ({1'b0, idx} == (count - (ADDR_W+1)'(1)));
  // start wins over a same-cycle load, so the offered vector is refused
  assign load_ready = rst_n && (state == S_IDLE) && (count < DEPTH_C) && !start;
  assign load_fire  = load_valid && load_ready;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign res_valid = (state == S_DRAIN);
  assign res_in    = res_valid ? vec_mem[idx] : '0;
  assign res_out   = res_valid ? res_mem[idx] : '0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      lut_in   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= (count == '0) ? S_DONE : S_DRIVE;
          end else if (load_fire) begin
            count <= count + (ADDR_W+1)'(1);
          end
        end
        S_DRIVE: begin
          lut_in   <= vec_mem[idx];
          wait_cnt <= SETTLE_M1;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CAPT;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        S_CAPT: begin
          if (last_idx) begin
            idx   <= '0;
            state <= S_DRAIN;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= S_DRIVE;
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (last_idx) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          count <= '0;
          idx   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffers carry no reset so they map onto plain RAM
  always_ff @(posedge clk) begin
    if (load_fire) vec_mem[count[ADDR_W-1:0]] <= load_data;
    if (state == S_CAPT) res_mem[idx] <= lut_out;
  end

endmodule

// File: doc/exp_lut_harness.md
Name: exp_lut_harness

Overview:
- Synthesizable vector player/recorder for the combinational exp_lut (32-bit in, 32-bit out).
- Host loads up to DEPTH input vectors and pulses start. The block then drives each vector onto the LUT, waits a settle window, and captures the LUT output.
- Captured (input, output) pairs are streamed back through a valid/ready result port.
- This is the on-chip counterpart to the file-driven stimulus/dump flow, so LUT characterisation runs on silicon or FPGA without a host simulator.

Parameters:
- DATA_W, 32, width of LUT input/output and of all data ports.
- DEPTH, 16, vector buffer and result buffer entries.
- ADDR_W, 4, index width; must satisfy 2**ADDR_W >= DEPTH.
- SETTLE, 1, cycles between driving lut_in and sampling lut_out; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load_valid  in  1  host offers a vector.
- load_data  in  DATA_W  vector value.
- load_ready  out  1  block accepts a vector this cycle.
- start  in  1  one-cycle request to run all loaded vectors.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.
- count  out  ADDR_W+1  number of loaded vectors.
- lut_in  out  DATA_W  registered drive to exp_lut d_in.
- lut_out  in  DATA_W  exp_lut d_out.
- res_valid  out  1  result pair available.
- res_ready  in  1  consumer accepts the pair.
- res_in  out  DATA_W  vector that produced the result.
- res_out  out  DATA_W  captured LUT output.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, count=0, idx=0, wait counter=0.
  - lut_in=0, load_ready=0 during the reset cycle, busy=0, done=0, res_valid=0, res_in=0, res_out=0.
  - Buffer contents are don't-care.
  - Reset in any state aborts the run immediately; no done pulse.
- IDLE:
  - load_ready = (count < DEPTH).
  - On load_valid && load_ready: vec[count] <= load_data and count increments.
  - start has priority over a same-cycle load. The load is not accepted (load_ready is forced 0 when start=1) and the FSM goes to DRIVE.
  - start with count=0: go directly to DONE (done pulses next cycle).
- DRIVE:
  - lut_in <= vec[idx]; wait counter <= SETTLE-1; next state WAIT.
- WAIT:
  - Decrement the counter; leave for CAPT when it is 0.
  - Time from DRIVE to CAPT is SETTLE+1 edges, so lut_out is stable for at least SETTLE full cycles.
- CAPT:
  - res[idx] <= lut_out.
  - If idx == count-1: idx <= 0 and go to DRAIN.
  - Otherwise idx increments and go to DRIVE.
  - Throughput: SETTLE+2 cycles per vector.
- DRAIN:
  - res_valid=1, res_in=vec[idx], res_out=res[idx].
  - On res_valid && res_ready: idx increments. On the last pair, go to DONE.
  - When res_ready=0, outputs hold stable and the block waits indefinitely.
- DONE:
  - done=1 for exactly one cycle.
  - count <= 0, idx <= 0, then IDLE.
- Stable outputs:
  - lut_in holds its last driven value outside DRIVE.
  - res_in and res_out are 0 when res_valid=0.
- Ignored inputs:
  - start outside IDLE is ignored.
  - load_valid outside IDLE is ignored (load_ready=0).
- Buffer full: with count==DEPTH, load_ready=0 and further loads are dropped without side effect; start still runs all DEPTH vectors.
- Width rules:
  - No arithmetic on data; values pass bit-exact.
  - count saturates at DEPTH and never wraps.
  - idx never exceeds count-1.

Test Plan:
- Basic run (SETTLE=1, bench stub lut_out = lut_in + 1):
  - Stimulus: load 32'h00000001, 32'h3F800000, 32'hFFFFFFFF; pulse start.
  - Required: pairs (1,2), (3F800000,3F800001), (FFFFFFFF,00000000) in order.
  - Required: CAPT cycles 3 cycles apart; done pulses one cycle after the last handshake; count returns to 0.
- Full buffer:
  - Stimulus: offer 17 vectors 0..16.
  - Required: load_ready drops after the 16th; count=16; vector 16 never appears in the results; run emits 16 pairs.
- Backpressure and settle:
  - Stimulus: res_ready toggling 1,0,0,1.
  - Required: res_in/res_out held while stalled; no pair duplicated or lost.
  - Stimulus: with SETTLE=4, stub output delayed 3 cycles via a registered chain.
  - Required: captured values correct.
- Empty start and start priority:
  - Stimulus: start with count=0.
  - Required: busy for 1 cycle, done pulse, res_valid never high.
  - Stimulus: start coincident with load_valid.
  - Required: that load is rejected.
- Reset mid-run:
  - Stimulus: assert rst_n=0 during WAIT of vector 2, then pulse start.
  - Required: next cycle busy=0, lut_in=0, count=0, no done pulse; subsequent start gives immediate done.
